// File: rtl/paint_pkg.sv
// Shared encodings and size helpers for the paint cell buffer.
package paint_pkg;

    typedef enum logic [1:0] {
        OP_PAINT = 2'd0,
        OP_ERASE = 2'd1,
        OP_CLEAR = 2'd2,
        OP_RSVD  = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_SETUP = 3'd2,
        ST_STAMP = 3'd3,
        ST_CLEAR = 3'd4
    } state_e;

    // Width of a packed {r,g,b} colour word.
    function automatic int unsigned rgb_w(input int unsigned color_w);
        return 3 * color_w;
    endfunction

    function automatic int unsigned cells(input int unsigned res, input int unsigned scale);
        return res / scale;
    endfunction

    // Index width for n entries, never below one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/paint_cell_buffer_if.sv
// Command handshake between the brush controller and the cell buffer.
interface paint_cell_buffer_if
    import paint_pkg::*;
#(
    parameter int unsigned CX_W     = 8,
    parameter int unsigned CY_W     = 7,
    parameter int unsigned RADIUS_W = 3,
    parameter int unsigned COLOR_W  = 4
) ();

    logic                        cmd_valid;
    logic                        cmd_ready;
    logic [1:0]                  cmd_op;
    logic [CX_W-1:0]             cmd_cx;
    logic [CY_W-1:0]             cmd_cy;
    logic [RADIUS_W-1:0]         cmd_radius;
    logic [rgb_w(COLOR_W)-1:0]   cmd_color;
    logic                        busy;
    logic                        done;

    modport master (
        output cmd_valid, cmd_op, cmd_cx, cmd_cy, cmd_radius, cmd_color,
        input  cmd_ready, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_cx, cmd_cy, cmd_radius, cmd_color,
        output cmd_ready, busy, done
    );

endinterface

// File: rtl/paint_cell_ram.sv
// Simple dual-port read-first RAM with registered read; contents are not reset.
module paint_cell_ram #(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned ADDR_W = 15
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Read sees the pre-write contents on a same-address collision.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/paint_cell_buffer.sv
// Cell-granular colour buffer: command FSM on the write port, VGA scan on the read port.
module paint_cell_buffer
    import paint_pkg::*;
#(
    parameter int unsigned H_RES    = 640,
    parameter int unsigned V_RES    = 480,
    parameter int unsigned SCALE    = 4,
    parameter int unsigned COLOR_W  = 4,
    parameter int unsigned RADIUS_W = 3,
    parameter logic [rgb_w(COLOR_W)-1:0] BG_COLOR = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [9:0]         pix_x,
    input  logic [9:0]         pix_y,
    input  logic               pix_active,
    output logic [COLOR_W-1:0] vga_red,
    output logic [COLOR_W-1:0] vga_green,
    output logic [COLOR_W-1:0] vga_blue,
    paint_cell_buffer_if.slave cmd
);

    localparam int unsigned H_CELLS  = cells(H_RES, SCALE);
    localparam int unsigned V_CELLS  = cells(V_RES, SCALE);
    localparam int unsigned N_CELLS  = H_CELLS * V_CELLS;
    localparam int unsigned CX_W     = idx_w(H_CELLS);
    localparam int unsigned CY_W     = idx_w(V_CELLS);
    localparam int unsigned ADDR_W   = idx_w(N_CELLS);
    localparam int unsigned DATA_W   = rgb_w(COLOR_W);
    localparam int unsigned SCALE_SH = $clog2(SCALE);
    localparam int unsigned H_SH     = $clog2(H_CELLS);
    localparam bit          H_POW2   = ((H_CELLS & (H_CELLS - 1)) == 0);
    localparam int          H_MAX    = int'(H_CELLS) - 1;
    localparam int          V_MAX    = int'(V_CELLS) - 1;

    function automatic logic [ADDR_W-1:0] cell_addr(input logic [CX_W-1:0] x,
                                                     input logic [CY_W-1:0] y);
        if (H_POW2) begin
            return (ADDR_W'(y) << H_SH) + ADDR_W'(x);
        end
        return ADDR_W'(y) * ADDR_W'(H_CELLS) + ADDR_W'(x);
    endfunction

    state_e              state, state_nx;
    op_e                 op_q;
    logic [CX_W-1:0]     cx_q, bx0_q, bx1_q, cur_x;
    logic [CY_W-1:0]     cy_q, by0_q, by1_q, cur_y;
    logic [RADIUS_W-1:0] r_q;
    logic [DATA_W-1:0]   color_q;
    logic [ADDR_W-1:0]   sweep_q;
    logic                ready_q, busy_q, done_q;
    logic                ready_d, busy_d, done_d;
    logic                we_c;
    logic [ADDR_W-1:0]   waddr_c, raddr_c;
    logic [DATA_W-1:0]   wdata_c, rdata;
    logic                sweep_last, stamp_last, region_empty, in_range, vis_q;
    int                  lo_x, hi_x, lo_y, hi_y, x0_s, x1_s, y0_s, y1_s;

    assign sweep_last = (sweep_q == ADDR_W'(N_CELLS - 1));
    assign stamp_last = (cur_x == bx1_q) && (cur_y == by1_q);

    // Brush bounds clipped to the grid in signed arithmetic so off-grid centres clip cleanly.
    always_comb begin
        lo_x = int'(cx_q) - int'(r_q);
        hi_x = int'(cx_q) + int'(r_q);
        lo_y = int'(cy_q) - int'(r_q);
        hi_y = int'(cy_q) + int'(r_q);
        x0_s = (lo_x < 0) ? 0 : lo_x;
        x1_s = (hi_x > H_MAX) ? H_MAX : hi_x;
        y0_s = (lo_y < 0) ? 0 : lo_y;
        y1_s = (hi_y > V_MAX) ? V_MAX : hi_y;
        region_empty = (x0_s > x1_s) || (y0_s > y1_s);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_INIT;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_INIT:  if (sweep_last) state_nx = ST_IDLE;
            ST_IDLE:  if (cmd.cmd_valid) state_nx = ST_SETUP;
            ST_SETUP: begin
                case (op_q)
                    OP_PAINT, OP_ERASE: state_nx = region_empty ? ST_IDLE : ST_STAMP;
                    OP_CLEAR:           state_nx = ST_CLEAR;
                    default:            state_nx = ST_IDLE;
                endcase
            end
            ST_STAMP: if (stamp_last) state_nx = ST_IDLE;
            ST_CLEAR: if (sweep_last) state_nx = ST_IDLE;
            default:  state_nx = ST_INIT;
        endcase
    end

    // Status looks one state ahead so the registered flags line up with the state.
    always_comb begin
        ready_d = (state_nx == ST_IDLE);
        busy_d  = (state_nx != ST_IDLE);
        done_d  = ((state == ST_SETUP) && (state_nx == ST_IDLE)) ||
                  ((state == ST_STAMP) && stamp_last) ||
                  ((state == ST_CLEAR) && sweep_last);
        we_c    = (state == ST_INIT) || (state == ST_CLEAR) || (state == ST_STAMP);
        waddr_c = (state == ST_STAMP) ? cell_addr(cur_x, cur_y) : sweep_q;
        wdata_c = ((state == ST_STAMP) && (op_q == OP_PAINT)) ? color_q : BG_COLOR;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign cmd.cmd_ready = ready_q;
    assign cmd.busy      = busy_q;
    assign cmd.done      = done_q;

    // Command latch, clipped bounds and sweep counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= OP_PAINT;
            cx_q    <= '0;
            cy_q    <= '0;
            r_q     <= '0;
            color_q <= '0;
            bx0_q   <= '0;
            bx1_q   <= '0;
            by0_q   <= '0;
            by1_q   <= '0;
            cur_x   <= '0;
            cur_y   <= '0;
            sweep_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd.cmd_valid) begin
                        op_q    <= op_e'(cmd.cmd_op);
                        cx_q    <= cmd.cmd_cx;
                        cy_q    <= cmd.cmd_cy;
                        r_q     <= cmd.cmd_radius;
                        color_q <= cmd.cmd_color;
                    end
                end
                ST_SETUP: begin
                    bx0_q   <= CX_W'(x0_s);
                    bx1_q   <= CX_W'(x1_s);
                    by0_q   <= CY_W'(y0_s);
                    by1_q   <= CY_W'(y1_s);
                    cur_x   <= CX_W'(x0_s);
                    cur_y   <= CY_W'(y0_s);
                    sweep_q <= '0;
                end
                ST_STAMP: begin
                    if (cur_x == bx1_q) begin
                        cur_x <= bx0_q;
                        cur_y <= cur_y + CY_W'(1);
                    end else begin
                        cur_x <= cur_x + CX_W'(1);
                    end
                end
                ST_INIT, ST_CLEAR: sweep_q <= sweep_q + ADDR_W'(1);
                default: ;
            endcase
        end
    end

    assign in_range = pix_active &&
                      ({1'b0, pix_x} < 11'(H_RES)) &&
                      ({1'b0, pix_y} < 11'(V_RES));
    assign raddr_c  = in_range ? cell_addr(CX_W'(pix_x >> SCALE_SH), CY_W'(pix_y >> SCALE_SH))
                               : '0;

    paint_cell_ram #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk  (clk),
        .we   (we_c),
        .waddr(waddr_c),
        .wdata(wdata_c),
        .raddr(raddr_c),
        .rdata(rdata)
    );

    // Second read stage: blank anything outside the visible area.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vis_q     <= 1'b0;
            vga_red   <= '0;
            vga_green <= '0;
            vga_blue  <= '0;
        end else begin
            vis_q     <= in_range;
            vga_red   <= vis_q ? rdata[3*COLOR_W-1:2*COLOR_W] : '0;
            vga_green <= vis_q ? rdata[2*COLOR_W-1:COLOR_W]   : '0;
            vga_blue  <= vis_q ? rdata[COLOR_W-1:0]           : '0;
        end
    end

endmodule

// File: tb/tb_paint_cell_buffer.sv
// Directed bench for paint_cell_buffer: probe table plus hand-timed corner sequences.
module tb_paint_cell_buffer;
    import paint_pkg::*;

    localparam int K_CELLS = 19200;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] pix_x, pix_y;
    logic       pix_active;
    logic [3:0] vga_red, vga_green, vga_blue;
    logic [11:0] rgb;

    int n_total = 0;
    int n_pass  = 0;

    paint_cell_buffer_if cmd_if ();

    paint_cell_buffer u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_active(pix_active),
        .vga_red   (vga_red),
        .vga_green (vga_green),
        .vga_blue  (vga_blue),
        .cmd       (cmd_if)
    );

    always #5 clk = ~clk;
    assign rgb = {vga_red, vga_green, vga_blue};

    typedef struct {
        int          phase;
        int          x;
        int          y;
        logic        act;
        logic [11:0] exp;
    } probe_t;

    probe_t tbl[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic set_pix(input int x, input int y, input logic act);
        pix_x      = 10'(x);
        pix_y      = 10'(y);
        pix_active = act;
    endtask

    task automatic run_phase(input int ph);
        foreach (tbl[i]) begin
            if (tbl[i].phase == ph) begin
                set_pix(tbl[i].x, tbl[i].y, tbl[i].act);
                repeat (2) @(negedge clk);
                check($sformatf("probe%0d_(%0d,%0d,a%0d)", ph, tbl[i].x, tbl[i].y, tbl[i].act),
                      32'(rgb), 32'(tbl[i].exp));
            end
        end
    endtask

    task automatic init_count(input string tag);
        int cnt;
        bit seen;
        cnt  = 0;
        seen = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 25000; i++) begin
            if (!cmd_if.busy) break;
            cnt++;
            if (cmd_if.done) seen = 1'b1;
            @(negedge clk);
        end
        check({tag, "_busy_cycles"}, 32'(cnt), 32'(K_CELLS));
        check({tag, "_no_done"}, 32'(seen), 32'd0);
        check({tag, "_ready"}, 32'(cmd_if.cmd_ready), 32'd1);
    endtask

    // Leaves the bench at the negedge of the acceptance cycle with valid high.
    task automatic accept(input string tag, input logic [1:0] op, input int cx, input int cy,
                          input int r, input logic [11:0] col);
        for (int i = 0; i < 200; i++) begin
            if (cmd_if.cmd_ready) break;
            @(negedge clk);
        end
        check({tag, "_ready_wait"}, 32'(cmd_if.cmd_ready), 32'd1);
        cmd_if.cmd_op     = op;
        cmd_if.cmd_cx     = 8'(cx);
        cmd_if.cmd_cy     = 7'(cy);
        cmd_if.cmd_radius = 3'(r);
        cmd_if.cmd_color  = col;
        cmd_if.cmd_valid  = 1'b1;
    endtask

    task automatic do_cmd(input string tag, input logic [1:0] op, input int cx, input int cy,
                          input int r, input logic [11:0] col, input int exp_lat);
        int lat;
        lat = -1;
        accept(tag, op, cx, cy, r, col);
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (i == 1) cmd_if.cmd_valid = 1'b0;
            if (cmd_if.done) begin
                lat = i;
                break;
            end
        end
        check({tag, "_done_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_ready_at_done"}, 32'(cmd_if.cmd_ready), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bcnt;
        bit seen;

        tbl.push_back('{0, 0,   0,   1'b1, 12'h000});
        tbl.push_back('{0, 320, 240, 1'b1, 12'h000});
        tbl.push_back('{0, 639, 479, 1'b1, 12'h000});
        tbl.push_back('{1, 36,  36,  1'b1, 12'hF80});
        tbl.push_back('{1, 47,  47,  1'b1, 12'hF80});
        tbl.push_back('{1, 40,  44,  1'b1, 12'hF80});
        tbl.push_back('{1, 35,  36,  1'b1, 12'h000});
        tbl.push_back('{1, 48,  40,  1'b1, 12'h000});
        tbl.push_back('{1, 40,  35,  1'b1, 12'h000});
        tbl.push_back('{1, 47,  48,  1'b1, 12'h000});
        tbl.push_back('{1, 36,  36,  1'b0, 12'h000});
        tbl.push_back('{2, 0,   0,   1'b1, 12'h0A5});
        tbl.push_back('{2, 11,  11,  1'b1, 12'h0A5});
        tbl.push_back('{2, 12,  0,   1'b1, 12'h000});
        tbl.push_back('{2, 0,   12,  1'b1, 12'h000});
        tbl.push_back('{2, 639, 0,   1'b1, 12'h000});
        tbl.push_back('{2, 0,   479, 1'b1, 12'h000});
        tbl.push_back('{2, 639, 479, 1'b1, 12'h000});
        tbl.push_back('{2, 40,  40,  1'b1, 12'hF80});
        tbl.push_back('{3, 639, 479, 1'b1, 12'hFFF});
        tbl.push_back('{3, 636, 476, 1'b1, 12'hFFF});
        tbl.push_back('{3, 635, 479, 1'b1, 12'h000});
        tbl.push_back('{3, 639, 475, 1'b1, 12'h000});
        tbl.push_back('{3, 640, 479, 1'b1, 12'h000});
        tbl.push_back('{3, 639, 480, 1'b1, 12'h000});
        tbl.push_back('{3, 40,  40,  1'b1, 12'hF80});
        tbl.push_back('{4, 36,  36,  1'b1, 12'h000});
        tbl.push_back('{4, 47,  47,  1'b1, 12'h000});
        tbl.push_back('{4, 0,   0,   1'b1, 12'h0A5});

        rst_n             = 1'b0;
        cmd_if.cmd_valid  = 1'b0;
        cmd_if.cmd_op     = 2'd0;
        cmd_if.cmd_cx     = '0;
        cmd_if.cmd_cy     = '0;
        cmd_if.cmd_radius = '0;
        cmd_if.cmd_color  = '0;
        set_pix(0, 0, 1'b0);
        repeat (3) @(negedge clk);

        check("rst_ready", 32'(cmd_if.cmd_ready), 32'd0);
        check("rst_busy",  32'(cmd_if.busy),      32'd1);
        check("rst_done",  32'(cmd_if.done),      32'd0);
        check("rst_vga",   32'(rgb),              32'd0);

        init_count("init");
        run_phase(0);

        do_cmd("centre", OP_PAINT, 10, 10, 1, 12'hF80, 11);
        run_phase(1);
        do_cmd("corner", OP_PAINT, 0, 0, 2, 12'h0A5, 11);
        run_phase(2);
        do_cmd("single", OP_PAINT, 159, 119, 0, 12'hFFF, 3);
        do_cmd("rsvd",   OP_RSVD, 10, 10, 1, 12'hFFF, 2);
        do_cmd("offgrid_empty", OP_PAINT, 200, 5, 1, 12'hFFF, 2);
        run_phase(3);
        do_cmd("erase",  OP_ERASE, 10, 10, 1, 12'hFFF, 11);
        run_phase(4);

        // Clear with the last-swept cell on screen, blanking mid-sweep.
        set_pix(639, 479, 1'b1);
        repeat (2) @(negedge clk);
        check("pre_clear", 32'(rgb), 32'hFFF);
        accept("clear", OP_CLEAR, 0, 0, 0, 12'h000);
        lat  = -1;
        bcnt = 0;
        for (int i = 1; i <= 20000; i++) begin
            @(negedge clk);
            if (i == 1) cmd_if.cmd_valid = 1'b0;
            if (cmd_if.busy) bcnt++;
            if (i == 10) begin
                check("clear_partial_vis", 32'(rgb), 32'hFFF);
                pix_active = 1'b0;
            end
            if (i == 11) check("blank_lag1", 32'(rgb), 32'hFFF);
            if (i == 12) check("blank_lag2", 32'(rgb), 32'h000);
            if (cmd_if.done) begin
                lat = i;
                break;
            end
        end
        check("clear_done_latency", 32'(lat),  32'(K_CELLS + 2));
        check("clear_busy_cycles",  32'(bcnt), 32'(K_CELLS + 1));
        check("clear_ready",        32'(cmd_if.cmd_ready), 32'd1);
        pix_active = 1'b1;
        repeat (2) @(negedge clk);
        check("post_clear", 32'(rgb), 32'h000);

        // Reset during a clear sweep.
        do_cmd("repaint", OP_PAINT, 159, 119, 0, 12'hFFF, 3);
        repeat (2) @(negedge clk);
        check("repaint_vis", 32'(rgb), 32'hFFF);
        accept("clear2", OP_CLEAR, 0, 0, 0, 12'h000);
        seen = 1'b0;
        for (int i = 1; i <= 502; i++) begin
            @(negedge clk);
            if (i == 1) cmd_if.cmd_valid = 1'b0;
            if (cmd_if.done) seen = 1'b1;
        end
        check("clear2_no_early_done", 32'(seen), 32'd0);
        rst_n = 1'b0;
        #1;
        check("midrst_vga",   32'(rgb),              32'd0);
        check("midrst_ready", 32'(cmd_if.cmd_ready), 32'd0);
        check("midrst_done",  32'(cmd_if.done),      32'd0);
        check("midrst_busy",  32'(cmd_if.busy),      32'd1);
        repeat (2) @(negedge clk);
        init_count("reinit");
        repeat (2) @(negedge clk);
        check("reinit_cell", 32'(rgb), 32'h000);

        // Read a cell in the very cycle it is written.
        accept("coll", OP_PAINT, 50, 50, 0, 12'h123);
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
        @(negedge clk);
        set_pix(200, 200, 1'b1);
        @(negedge clk);
        check("coll_done", 32'(cmd_if.done), 32'd1);
        @(negedge clk);
        check("coll_old", 32'(rgb), 32'h000);
        @(negedge clk);
        check("coll_new", 32'(rgb), 32'h123);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
